// File: rtl/idli_sqi_ctrl_m_if.sv
// idli_sqi_ctrl_m_if: core request/response handshake plus external SQI SRAM pins.
interface idli_sqi_ctrl_m_if;
  logic        i_sqi_req_vld;
  logic        o_sqi_req_rdy;
  logic        i_sqi_req_wr;
  logic [15:0] i_sqi_req_addr;
  logic [15:0] i_sqi_req_wdata;
  logic        o_sqi_rsp_vld;
  logic [15:0] o_sqi_rsp_rdata;
  logic        o_sqi_mem_sck;
  logic        o_sqi_mem_cs;
  logic        o_sqi_mem_io_mode;
  logic [3:0]  o_sqi_mem_sio;
  logic [3:0]  i_sqi_mem_sio;
  modport slave (
    input  i_sqi_req_vld, i_sqi_req_wr, i_sqi_req_addr, i_sqi_req_wdata, i_sqi_mem_sio,
    output o_sqi_req_rdy, o_sqi_rsp_vld, o_sqi_rsp_rdata,
    output o_sqi_mem_sck, o_sqi_mem_cs, o_sqi_mem_io_mode, o_sqi_mem_sio
  );
  modport master (
    output i_sqi_req_vld, i_sqi_req_wr, i_sqi_req_addr, i_sqi_req_wdata, i_sqi_mem_sio,
    input  o_sqi_req_rdy, o_sqi_rsp_vld, o_sqi_rsp_rdata,
    input  o_sqi_mem_sck, o_sqi_mem_cs, o_sqi_mem_io_mode, o_sqi_mem_sio
  );
endinterface

// File: rtl/idli_sqi_ctrl_m.sv
// idli_sqi_ctrl_m: 16-bit read/write requests to SQI SRAM transactions (cmd, addr, dummy, data).
// Define IDLI_SQI_SEQ_EN to keep CS low after a transfer so address+2 requests skip straight to DATA.
package idli_pkg;
  localparam logic SQI_IO_MODE_OUT = 1'b0;
  localparam logic SQI_IO_MODE_IN  = 1'b1;
endpackage

module idli_sqi_ctrl_m
  import idli_pkg::*;
(
  input logic              i_sqi_gck,
  input logic              i_sqi_rst,
  idli_sqi_ctrl_m_if.slave bus
);
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DUMMY = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_END   = 3'd5;
  localparam logic [2:0] ST_HOLD  = 3'd6;
`ifdef IDLI_SQI_SEQ_EN
  localparam logic [2:0] ST_FIN = ST_HOLD;
`else
  localparam logic [2:0] ST_FIN = ST_END;
`endif

  logic [2:0]  state_q, state_d;
  logic        ph_q, ph_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [11:0] rdata_q, rdata_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic        pend_q, pend_d;
  logic        rdy_q, rdy_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic        sck_q, sck_d;
  logic        cs_q, cs_d;
  logic        io_q, io_d;
  logic [3:0]  sio_q, sio_d;
  logic        acc, last, active;

  assign acc  = bus.i_sqi_req_vld && rdy_q;
  assign last = (state_q == ST_ADDR || state_q == ST_DATA) ? cnt_q == 2'd3 : cnt_q == 2'd1;
`ifdef IDLI_SQI_SEQ_EN
  logic seq;
  assign seq = bus.i_sqi_req_wr == wr_q && bus.i_sqi_req_addr == addr_q + 16'd2;
`endif

  // ph_q=0 is phase A (sck low), ph_q=1 is phase B (sck high); slots advance at the end of B
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_vld_d   = 1'b0;
    pend_d      = pend_q;
    if (acc) begin
      wr_d    = bus.i_sqi_req_wr;
      addr_d  = bus.i_sqi_req_addr;
      wdata_d = bus.i_sqi_req_wdata;
      ph_d    = 1'b0;
      cnt_d   = 2'd0;
      state_d = ST_CMD;
`ifdef IDLI_SQI_SEQ_EN
      if (state_q == ST_HOLD) begin
        state_d = seq ? ST_DATA : ST_END;
        pend_d  = !seq;
      end
`endif
    end else if (state_q != ST_IDLE && state_q != ST_HOLD) begin
      ph_d = !ph_q;
      if (ph_q && state_q == ST_END) begin
        state_d = pend_q ? ST_CMD : ST_IDLE;
        pend_d  = 1'b0;
      end else if (ph_q) begin
        cnt_d = last ? 2'd0 : cnt_q + 2'd1;
        if (state_q == ST_DATA && !wr_q) rdata_d = {rdata_q[7:0], bus.i_sqi_mem_sio};
        if (last) state_d = state_q == ST_CMD   ? ST_ADDR :
                            state_q == ST_ADDR  ? (wr_q ? ST_DATA : ST_DUMMY) :
                            state_q == ST_DUMMY ? ST_DATA : ST_FIN;
        if (last && state_q == ST_DATA) begin
          rsp_vld_d = 1'b1;
          if (!wr_q) rsp_rdata_d = {rdata_q, bus.i_sqi_mem_sio};
        end
      end
    end
  end

  // pins are registered from the next state so they change cleanly on the clock edge
  always_comb begin
    active = state_d == ST_CMD || state_d == ST_ADDR || state_d == ST_DUMMY || state_d == ST_DATA;
    rdy_d  = state_d == ST_IDLE || state_d == ST_HOLD;
    cs_d   = !(active || state_d == ST_HOLD);
    sck_d  = active && ph_d;
    io_d   = (state_d == ST_DUMMY || (state_d == ST_DATA && !wr_d)) ? SQI_IO_MODE_IN : SQI_IO_MODE_OUT;
    sio_d  = state_d == ST_CMD             ? (cnt_d == 2'd0 ? 4'h0 : (wr_d ? 4'h2 : 4'h3)) :
             state_d == ST_ADDR            ? addr_d[{~cnt_d, 2'b00} +: 4] :
             (state_d == ST_DATA && wr_d)  ? wdata_d[{~cnt_d, 2'b00} +: 4] : 4'h0;
  end

  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) begin
      state_q     <= ST_IDLE;
      ph_q        <= 1'b0;
      cnt_q       <= 2'd0;
      wr_q        <= 1'b0;
      addr_q      <= 16'h0;
      wdata_q     <= 16'h0;
      rdata_q     <= 12'h0;
      rsp_rdata_q <= 16'h0;
      pend_q      <= 1'b0;
      rdy_q       <= 1'b0;
      rsp_vld_q   <= 1'b0;
      sck_q       <= 1'b0;
      cs_q        <= 1'b1;
      io_q        <= SQI_IO_MODE_OUT;
      sio_q       <= 4'h0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      pend_q      <= pend_d;
      rdy_q       <= rdy_d;
      rsp_vld_q   <= rsp_vld_d;
      sck_q       <= sck_d;
      cs_q        <= cs_d;
      io_q        <= io_d;
      sio_q       <= sio_d;
    end
  end

  assign bus.o_sqi_req_rdy     = rdy_q;
  assign bus.o_sqi_rsp_vld     = rsp_vld_q;
  assign bus.o_sqi_rsp_rdata   = rsp_rdata_q;
  assign bus.o_sqi_mem_sck     = sck_q;
  assign bus.o_sqi_mem_cs      = cs_q;
  assign bus.o_sqi_mem_io_mode = io_q;
  assign bus.o_sqi_mem_sio     = sio_q;
endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// tb_idli_sqi_ctrl_m: directed bench with response scoreboard and a small SQI SRAM pin model.
module tb_idli_sqi_ctrl_m;
  import idli_pkg::*;

  typedef struct packed {logic wr; logic [15:0] data;} exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;
  int acc_cnt = 0;
  exp_t sbq[$];
  logic [15:0] rd_word = 16'h0;
  logic [39:0] wcap = 40'h0;
  logic [39:0] wexp;
  int idx = 0;
  logic sck_p = 1'b0;

  idli_sqi_ctrl_m_if bus();

  idli_sqi_ctrl_m dut (.i_sqi_gck(clk), .i_sqi_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // returns in cycle 1 (the cycle after the acceptance edge)
  task automatic do_req(input logic wr, input logic [15:0] a, input logic [15:0] d, input logic [15:0] expd);
    bus.i_sqi_req_wr    = wr;
    bus.i_sqi_req_addr  = a;
    bus.i_sqi_req_wdata = d;
    bus.i_sqi_req_vld   = 1'b1;
    for (int i = 0; i < 100 && bus.o_sqi_req_rdy !== 1'b1; i++) tick();
    chk("req_rdy", bus.o_sqi_req_rdy, 1);
    tick();
    bus.i_sqi_req_vld = 1'b0;
    sbq.push_back('{wr, wr ? 16'h0 : expd});
  endtask

  task automatic rsp_at(input string tag, input int start, input int exp_c);
    int c = start;
    while (bus.o_sqi_rsp_vld !== 1'b1 && c < 60) begin
      tick();
      c++;
    end
    chk(tag, c, exp_c);
  endtask

  // SRAM model: counts nibbles per CS-low window and serves rd_word on data nibbles
  always @(negedge clk) begin
    if (bus.o_sqi_mem_cs !== 1'b0) idx = 0;
    bus.i_sqi_mem_sio = idx >= 8 ? rd_word[{~2'(idx), 2'b00} +: 4] : 4'h0;
    if (bus.o_sqi_mem_cs === 1'b0 && bus.o_sqi_mem_sck === 1'b1 && !sck_p) begin
      idx++;
      wcap = {wcap[35:0], bus.o_sqi_mem_sio};
    end
    sck_p = bus.o_sqi_mem_sck === 1'b1;
    if (bus.i_sqi_req_vld === 1'b1 && bus.o_sqi_req_rdy === 1'b1) acc_cnt++;
  end

  always @(negedge clk) begin
    if (bus.o_sqi_rsp_vld === 1'b1) begin
      exp_t e;
      rsp_cnt++;
      chk("sb_nonempty", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        if (!e.wr) chk("sb_rdata", bus.o_sqi_rsp_rdata, e.data);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_at, hi_run, r0, a0;
    logic rdy_prev;
    bus.i_sqi_req_vld   = 1'b0;
    bus.i_sqi_req_wr    = 1'b0;
    bus.i_sqi_req_addr  = 16'h0;
    bus.i_sqi_req_wdata = 16'h0;
    bus.i_sqi_mem_sio   = 4'h0;
    tick();
    tick();
    chk("rst_rdy", bus.o_sqi_req_rdy, 0);
    chk("rst_cs", bus.o_sqi_mem_cs, 1);
    chk("rst_sck", bus.o_sqi_mem_sck, 0);
    chk("rst_io", bus.o_sqi_mem_io_mode, SQI_IO_MODE_OUT);
    chk("rst_sio", bus.o_sqi_mem_sio, 0);
    chk("rst_rspv", bus.o_sqi_rsp_vld, 0);
    chk("rst_rdata", bus.o_sqi_rsp_rdata, 0);
    rst = 1'b0;
    tick();
    chk("idle_rdy", bus.o_sqi_req_rdy, 1);
    // write 0x1234 to 0x00A0
    wexp = {8'h02, 16'h00A0, 16'h1234};
    do_req(1'b1, 16'h00A0, 16'h1234, 16'h0);
    for (int c = 1; c <= 23; c++) begin
      if (c > 1) tick();
      if (c <= 20) chk($sformatf("wr_cs_c%0d", c), bus.o_sqi_mem_cs, 0);
      if (c <= 20 && c % 2 == 0) begin
        chk($sformatf("wr_sck_c%0d", c), bus.o_sqi_mem_sck, 1);
        chk($sformatf("wr_sio_c%0d", c), bus.o_sqi_mem_sio, wexp[39 - 4 * (c / 2 - 1) -: 4]);
      end
      if (c == 21) chk("wr_rspv_c21", bus.o_sqi_rsp_vld, 1);
      if (c == 21 || c == 22) chk($sformatf("wr_cs_hi_c%0d", c), bus.o_sqi_mem_cs, 1);
      if (c == 22) chk("wr_rdy_c22", bus.o_sqi_req_rdy, 0);
      if (c == 23) chk("wr_rdy_c23", bus.o_sqi_req_rdy, 1);
    end
    // read 0x00A0 returning 0xBEEF
    rd_word = 16'hBEEF;
    do_req(1'b0, 16'h00A0, 16'h0, 16'hBEEF);
    for (int c = 1; c <= 27; c++) begin
      if (c > 1) tick();
      if (c <= 24) chk($sformatf("rd_cs_c%0d", c), bus.o_sqi_mem_cs, 0);
      if (c >= 12 && c <= 25)
        chk($sformatf("rd_io_c%0d", c), bus.o_sqi_mem_io_mode,
            (c >= 13 && c <= 24) ? SQI_IO_MODE_IN : SQI_IO_MODE_OUT);
      if (c == 25) begin
        chk("rd_rspv_c25", bus.o_sqi_rsp_vld, 1);
        chk("rd_rdata_c25", bus.o_sqi_rsp_rdata, 16'hBEEF);
      end
      if (c == 26) chk("rd_rdy_c26", bus.o_sqi_req_rdy, 0);
      if (c == 27) chk("rd_rdy_c27", bus.o_sqi_req_rdy, 1);
    end
    // read held valid straight after a write is accepted
    r0 = rsp_cnt;
    a0 = acc_cnt;
    rd_word = 16'h5A5A;
    do_req(1'b1, 16'h0200, 16'h9876, 16'h0);
    bus.i_sqi_req_wr   = 1'b0;
    bus.i_sqi_req_addr = 16'h0300;
    bus.i_sqi_req_vld  = 1'b1;
    rdy_prev = bus.o_sqi_req_rdy;
    acc_at = 0;
    hi_run = 0;
    for (int c = 2; c <= 60; c++) begin
      tick();
      if (bus.i_sqi_req_vld && rdy_prev) begin
        bus.i_sqi_req_vld = 1'b0;
        sbq.push_back('{1'b0, 16'h5A5A});
        acc_at = c;
      end
      rdy_prev = bus.o_sqi_req_rdy;
      if (c > 20 && acc_at == 0 && bus.o_sqi_mem_cs === 1'b1) hi_run++;
    end
    chk("b2b_acc_cycle", acc_at, 24);
    chk("b2b_cs_high_ge2", hi_run >= 2, 1);
    chk("b2b_acc_once", acc_cnt - a0, 2);
    chk("b2b_rsp_cnt", rsp_cnt - r0, 2);
    // reset in cycle 7 of a read
    tick();
    do_req(1'b0, 16'h0400, 16'h0, 16'h1111);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_cs", bus.o_sqi_mem_cs, 1);
    chk("mid_rst_sck", bus.o_sqi_mem_sck, 0);
    chk("mid_rst_rdy", bus.o_sqi_req_rdy, 0);
    chk("mid_rst_rdata", bus.o_sqi_rsp_rdata, 0);
    chk("mid_rst_io", bus.o_sqi_mem_io_mode, SQI_IO_MODE_OUT);
    rst = 1'b0;
    sbq.delete();
    r0 = rsp_cnt;
    repeat (30) tick();
    chk("abort_no_rsp", rsp_cnt, r0);
    do_req(1'b1, 16'h0100, 16'hCAFE, 16'h0);
    rsp_at("post_rst_wr_rsp", 1, 21);
    chk("post_rst_wr_nibs", wcap, {8'h02, 16'h0100, 16'hCAFE});
    repeat (3) tick();
`ifdef IDLI_SQI_SEQ_EN
    rd_word = 16'h1111;
    do_req(1'b0, 16'h0010, 16'h0, 16'h1111);
    rsp_at("seq_rd0_rsp", 1, 25);
    chk("seq_hold_cs", bus.o_sqi_mem_cs, 0);
    chk("seq_hold_rdy", bus.o_sqi_req_rdy, 1);
    rd_word = 16'h2222;
    do_req(1'b0, 16'h0012, 16'h0, 16'h2222);
    chk("seq_rd1_io", bus.o_sqi_mem_io_mode, SQI_IO_MODE_IN);
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) tick();
      chk($sformatf("seq_rd1_cs_c%0d", c), bus.o_sqi_mem_cs, 0);
    end
    tick();
    chk("seq_rd1_rspv_c9", bus.o_sqi_rsp_vld, 1);
    rd_word = 16'h3333;
    do_req(1'b0, 16'hFFFE, 16'h0, 16'h3333);
    chk("nseq_cs_c1", bus.o_sqi_mem_cs, 1);
    tick();
    chk("nseq_cs_c2", bus.o_sqi_mem_cs, 1);
    tick();
    chk("nseq_cs_c3", bus.o_sqi_mem_cs, 0);
    rsp_at("nseq_rsp", 3, 27);
    rd_word = 16'h4444;
    do_req(1'b0, 16'h0000, 16'h0, 16'h4444);
    chk("wrap_io", bus.o_sqi_mem_io_mode, SQI_IO_MODE_IN);
    rsp_at("wrap_rsp", 1, 9);
    rd_word = 16'h5555;
    do_req(1'b0, 16'h0040, 16'h0, 16'h5555);
    chk("jump_cs_c1", bus.o_sqi_mem_cs, 1);
    tick();
    chk("jump_cs_c2", bus.o_sqi_mem_cs, 1);
    tick();
    chk("jump_cs_c3", bus.o_sqi_mem_cs, 0);
    rsp_at("jump_rsp", 3, 27);
    repeat (3) tick();
`endif
    chk("sb_drained", sbq.size(), 0);
    chk("acc_vs_rsp", acc_cnt, rsp_cnt + 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
